pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It drives the hold and bubble controls of every inter-stage register (if_id, id_ex, ex_mem, mem_wb) from hazard and wait inputs. It also tracks outstanding instruction-fetch requests on the sram-like bus so that fetches in flight at an exception or eret are discarded.

---
 rtl/mycpu_pkg.sv | 18 +
 rtl/pipe_ctrl_fetch_cancel_tracker.sv | 78 +++++++
 rtl/pipe_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared pipeline-control definitions: fetch-cancel FSM states, stage indices
// and the default outstanding-fetch limit.
package mycpu_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        CANCEL = 1'b1
    } cancel_state_e;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int MAX_OUT_DEF = 2;

endpackage

// File: rtl/pipe_ctrl_fetch_cancel_tracker.sv
// Counts in-flight instruction fetches and, after an exception/eret, discards
// the responses of fetches that were issued before the redirect.
module fetch_cancel_tracker
    import mycpu_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic if_req_issue,
    input  logic if_data_ok,
    input  logic exc_req,
    output logic inst_discard,
    output logic fetch_block
);

    cancel_state_e    state, state_nxt;
    logic [CNT_W-1:0] outstanding, out_nxt;
    logic [CNT_W-1:0] cancel_cnt, cancel_nxt;
    logic [CNT_W:0]   out_sum;

    // Issue beyond MAX_OUT is a protocol error; clamp instead of wrapping.
    always_comb begin
        out_sum = {1'b0, outstanding} + (CNT_W+1)'(if_req_issue);
        if (if_data_ok && (out_sum != '0))
            out_sum = out_sum - (CNT_W+1)'(1);
        if (out_sum > (CNT_W+1)'(MAX_OUT))
            out_nxt = CNT_W'(MAX_OUT);
        else
            out_nxt = out_sum[CNT_W-1:0];
    end

    always_comb begin
        state_nxt    = state;
        cancel_nxt   = cancel_cnt;
        inst_discard = 1'b0;
        case (state)
            RUN: begin
                if (exc_req) begin
                    inst_discard = if_data_ok;
                    if (out_nxt != '0) begin
                        cancel_nxt = out_nxt;
                        state_nxt  = CANCEL;
                    end
                end
            end
            CANCEL: begin
                inst_discard = if_data_ok;
                if (exc_req) begin
                    // out_nxt already counts every live fetch, so reload rather than add.
                    cancel_nxt = out_nxt;
                    state_nxt  = (out_nxt != '0) ? CANCEL : RUN;
                end else if (if_data_ok && (cancel_cnt != '0)) begin
                    cancel_nxt = cancel_cnt - CNT_W'(1);
                    if (cancel_cnt == CNT_W'(1))
                        state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= RUN;
            outstanding <= '0;
            cancel_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            cancel_cnt  <= cancel_nxt;
        end
    end

    assign fetch_block = (outstanding == CNT_W'(MAX_OUT)) || (state == CANCEL) || exc_req;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus fetch-cancel tracking.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import mycpu_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req_issue,
    input  logic        if_data_ok,
    input  logic        if_empty,
    input  logic        id_load_use,
    input  logic        ex_busy,
    input  logic        mem_data_wait,
    input  logic        exc_req,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic        wb_flush,
    output logic        pc_redirect,
    output logic        fetch_block,
    output logic        inst_discard,
    output logic        if_inst_valid,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_cancel_cnt
);

    logic [STG_MEM:STG_IF] stall_v;
    logic [STG_WB:STG_ID]  flush_v;

    // Each branch stalls the stages upstream of the hazard and bubbles the one below it.
    always_comb begin
        stall_v     = '0;
        flush_v     = '0;
        pc_redirect = 1'b0;
        if (exc_req) begin
            flush_v[STG_ID]  = 1'b1;
            flush_v[STG_EX]  = 1'b1;
            flush_v[STG_MEM] = 1'b1;
            pc_redirect      = 1'b1;
        end else if (mem_data_wait) begin
            stall_v         = '1;
            flush_v[STG_WB] = 1'b1;
        end else if (ex_busy) begin
            stall_v[STG_IF]  = 1'b1;
            stall_v[STG_ID]  = 1'b1;
            stall_v[STG_EX]  = 1'b1;
            flush_v[STG_MEM] = 1'b1;
        end else if (id_load_use) begin
            stall_v[STG_IF] = 1'b1;
            stall_v[STG_ID] = 1'b1;
            flush_v[STG_EX] = 1'b1;
        end else if (if_empty) begin
            flush_v[STG_ID] = 1'b1;
        end
    end

    assign if_stall  = stall_v[STG_IF];
    assign id_stall  = stall_v[STG_ID];
    assign ex_stall  = stall_v[STG_EX];
    assign mem_stall = stall_v[STG_MEM];
    assign id_flush  = flush_v[STG_ID];
    assign ex_flush  = flush_v[STG_EX];
    assign mem_flush = flush_v[STG_MEM];
    assign wb_flush  = flush_v[STG_WB];

    fetch_cancel_tracker #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_tracker (
        .clk          (clk),
        .resetn       (resetn),
        .if_req_issue (if_req_issue),
        .if_data_ok   (if_data_ok),
        .exc_req      (exc_req),
        .inst_discard (inst_discard),
        .fetch_block  (fetch_block)
    );

    assign if_inst_valid = if_data_ok && !inst_discard;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, cancel_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_q  <= '0;
            cancel_cnt_q <= '0;
        end else begin
            if (if_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (inst_discard)
                cancel_cnt_q <= cancel_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_cancel_cnt = cancel_cnt_q;
`else
    assign perf_stall_cnt  = 32'd0;
    assign perf_cancel_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a per-cycle reference model and literal spot checks.
module tb_pipe_ctrl;

    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic resetn, if_req_issue, if_data_ok, if_empty, id_load_use, ex_busy, mem_data_wait, exc_req;
    logic if_stall, id_stall, ex_stall, mem_stall;
    logic id_flush, ex_flush, mem_flush, wb_flush;
    logic pc_redirect, fetch_block, inst_discard, if_inst_valid;
    logic [31:0] perf_stall_cnt, perf_cancel_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_OUT(MAX_OUT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .if_req_issue    (if_req_issue),
        .if_data_ok      (if_data_ok),
        .if_empty        (if_empty),
        .id_load_use     (id_load_use),
        .ex_busy         (ex_busy),
        .mem_data_wait   (mem_data_wait),
        .exc_req         (exc_req),
        .if_stall        (if_stall),
        .id_stall        (id_stall),
        .ex_stall        (ex_stall),
        .mem_stall       (mem_stall),
        .id_flush        (id_flush),
        .ex_flush        (ex_flush),
        .mem_flush       (mem_flush),
        .wb_flush        (wb_flush),
        .pc_redirect     (pc_redirect),
        .fetch_block     (fetch_block),
        .inst_discard    (inst_discard),
        .if_inst_valid   (if_inst_valid),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_cancel_cnt (perf_cancel_cnt)
    );

    // Output bundle order: 4 stalls (IF..MEM), 4 flushes (ID..WB), pc_redirect,
    // fetch_block, inst_discard, if_inst_valid.
    function automatic logic [11:0] dut_vec();
        return {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, mem_flush, wb_flush,
                pc_redirect, fetch_block, inst_discard, if_inst_valid};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: live fetch count and number of responses still to be dropped.
    int m_outs = 0;
    int m_drop = 0;
    int m_perf_stall = 0;
    int m_perf_cancel = 0;

    always @(negedge clk) begin
        int n_stall;
        int flush_stage;   // 0 none, 1 ID, 2 EX, 3 MEM, 4 WB
        logic [3:0] st, fl;
        logic redir, blk, disc, vld;
        logic [11:0] exp_v;
        int nxt;
        if (!resetn) begin
            m_outs = 0; m_drop = 0; m_perf_stall = 0; m_perf_cancel = 0;
        end else begin
            n_stall = 0; flush_stage = 0; redir = 0;
            if (exc_req)            redir = 1;
            else if (mem_data_wait) begin n_stall = 4; flush_stage = 4; end
            else if (ex_busy)       begin n_stall = 3; flush_stage = 3; end
            else if (id_load_use)   begin n_stall = 2; flush_stage = 2; end
            else if (if_empty)      flush_stage = 1;
            st = 4'b0;
            for (int i = 0; i < n_stall; i++) st[3-i] = 1'b1;
            fl = 4'b0;
            if (exc_req) fl = 4'b1110;
            else if (flush_stage != 0) fl[4-flush_stage] = 1'b1;
            disc  = if_data_ok && (exc_req || m_drop > 0);
            vld   = if_data_ok && !disc;
            blk   = (m_outs == MAX_OUT) || (m_drop > 0) || exc_req;
            exp_v = {st, fl, redir, blk, disc, vld};
            chk("model_ctl", {20'd0, dut_vec()}, {20'd0, exp_v});
`ifdef PIPE_CTRL_PERF_EN
            chk("model_perf_stall", perf_stall_cnt, m_perf_stall);
            chk("model_perf_cancel", perf_cancel_cnt, m_perf_cancel);
            if (st[3]) m_perf_stall++;
            if (disc)  m_perf_cancel++;
`else
            chk("model_perf_off", perf_stall_cnt | perf_cancel_cnt, 32'd0);
`endif
            nxt = m_outs + int'(if_req_issue) - int'(if_data_ok);
            if (nxt < 0) nxt = 0;
            if (nxt > MAX_OUT) nxt = MAX_OUT;
            if (exc_req) m_drop = nxt;
            else if (m_drop > 0 && if_data_ok) m_drop--;
            m_outs = nxt;
        end
    end

    task automatic cyc(input logic rn, input logic iss, input logic dok, input logic emp,
                       input logic lu, input logic busy, input logic mw, input logic exc);
        @(posedge clk);
        #1;
        resetn = rn; if_req_issue = iss; if_data_ok = dok; if_empty = emp;
        id_load_use = lu; ex_busy = busy; mem_data_wait = mw; exc_req = exc;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 0; if_req_issue = 0; if_data_ok = 0; if_empty = 0;
        id_load_use = 0; ex_busy = 0; mem_data_wait = 0; exc_req = 0;
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Out of reset, all inputs quiet.
        idle();
        chk("reset_ctl", {20'd0, dut_vec()}, 32'd0);
        chk("reset_perf", perf_stall_cnt | perf_cancel_cnt, 32'd0);

        // Load-use bubble, then clean cycle.
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        chk("loaduse_ctl", {20'd0, dut_vec()}, {20'd0, 12'b1100_0100_0000});
        idle();
        chk("loaduse_after", {20'd0, dut_vec()}, 32'd0);

        // Combined hazards: MEM wait dominates for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 1, 1, 1, 0);
            chk("stall_prio", {20'd0, dut_vec()}, {20'd0, 12'b1111_0001_0000});
        end
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        chk("ex_busy_only", {20'd0, dut_vec()}, {20'd0, 12'b1110_0010_0000});
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        chk("if_empty_only", {20'd0, dut_vec()}, {20'd0, 12'b0000_1000_0000});

        // Exception with two fetches outstanding.
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("two_out_block", fetch_block, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 1);
        chk("exc_over_memwait", {20'd0, dut_vec()}, {20'd0, 12'b0000_1110_1100});
        idle();
        chk("cancel_block", fetch_block, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        chk("drop1_disc", {31'd0, inst_discard}, 1);
        chk("drop1_valid", {31'd0, if_inst_valid}, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        chk("drop2_disc", {31'd0, inst_discard}, 1);
        chk("drop2_valid", {31'd0, if_inst_valid}, 0);
        idle();
        chk("cancel_done", {20'd0, dut_vec()}, 32'd0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        chk("new_fetch_valid", {31'd0, if_inst_valid}, 1);

        // Exception coinciding with the only outstanding data_ok.
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        chk("exc_dok_disc", {20'd0, dut_vec()}, {20'd0, 12'b0000_1110_1110});
        idle();
        chk("exc_dok_run", fetch_block, 0);

        // Re-exception in CANCEL while the last dropped response arrives.
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        chk("reexc_disc", {31'd0, inst_discard}, 1);
        idle();
        chk("reexc_run", fetch_block, 0);

        // Saturation: a third issue must not push the count past MAX_OUT.
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("sat_block", fetch_block, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("sat_no_wrap", fetch_block, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);

        // Reset while cancelling.
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("pre_reset_cancel", fetch_block, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("post_reset_ctl", {20'd0, dut_vec()}, 32'd0);
        chk("post_reset_perf_stall", perf_stall_cnt, 32'd0);
        chk("post_reset_perf_cancel", perf_cancel_cnt, 32'd0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        chk("post_reset_fetch", {31'd0, if_inst_valid}, 1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
